// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequential divide function.
//   ALU_WIDTH : default operand width for the divider
//   state_t   : divider FSM state encoding (IDLE, RUN, ZERO, DONE)
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtractor for one restoring-division step.
// Computes diff = a - b as a + ~b + 1 over WIDTH+1 bits.
// Ports:
//   a      in  WIDTH+1  shifted partial remainder
//   b      in  WIDTH+1  zero-extended divisor
//   diff   out WIDTH+1  a - b (modulo 2^(WIDTH+1))
//   borrow out 1        1 when a < b (the trial subtraction must be undone)
module div_trial_sub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  logic [WIDTH+1:0] sum;

  assign sum    = {1'b0, a} + {1'b0, ~b} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign diff   = sum[WIDTH:0];
  // Carry out of a + ~b + 1 is the inverse of the borrow.
  assign borrow = ~sum[WIDTH+1];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock.
// A start in IDLE or DONE latches A/B; WIDTH RUN cycles (or one ZERO cycle
// when B == 0) follow, then a one-cycle done pulse with Q/R valid.
// Optional feature: define SEQ_DIV_SIGNED_EN for two's-complement operands
// (truncating division, remainder takes the dividend's sign).
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   start       in   begin a divide (ignored while busy)
//   A, B        in   dividend, divisor
//   Q, R        out  quotient, remainder (registered, held)
//   busy        out  high in RUN and ZERO
//   done        out  one-cycle result pulse
//   div_by_zero out  set with done when B was 0, cleared at next accept
//   state       out  current FSM state, for observation
//
// Handshake: start is a request sampled on the rising edge; it is accepted
// only when state is IDLE or DONE (never queued). Every accepted start
// produces exactly one done pulse unless reset intervenes.
module seq_restoring_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output state_t           state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           next_state;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   p_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] b_q;

  logic             accept;
  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] d_next;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic [WIDTH-1:0] a_load;
  logic [WIDTH-1:0] b_load;
  logic             unused_p_msb;

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q_q;
  logic neg_r_q;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    // Most-negative maps to itself, which is its correct unsigned magnitude.
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction
`endif

  assign state  = state_r;
  assign busy   = (state_r == S_RUN) || (state_r == S_ZERO);
  assign done   = (state_r == S_DONE);
  assign accept = start && ((state_r == S_IDLE) || (state_r == S_DONE));

  // ---------------- next-state logic ----------------
  always_comb begin
    next_state = state_r;
    case (state_r)
      S_IDLE: if (start) next_state = (B == '0) ? S_ZERO : S_RUN;
      S_RUN:  if (cnt_q == LAST) next_state = S_DONE;
      S_ZERO: next_state = S_DONE;
      S_DONE: begin
        if (start) next_state = (B == '0) ? S_ZERO : S_RUN;
        else       next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------- one restoring step ----------------
  assign trial_a = {p_q[WIDTH-1:0], d_q[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
    .a      (trial_a),
    .b      ({1'b0, b_q}),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // The shifted remainder is always below 2*B, so the borrow is exactly the
  // sign of the trial difference; on borrow the shifted value is kept.
  assign p_next = trial_borrow ? trial_a : trial_diff;
  assign d_next = {d_q[WIDTH-2:0], ~trial_borrow};

  // Final quotient/remainder written on the transition into DONE.
  always_comb begin
    q_fin = d_next;
    r_fin = p_next[WIDTH-1:0];
`ifdef SEQ_DIV_SIGNED_EN
    if (neg_q_q) q_fin = ~d_next + 1'b1;
    if (neg_r_q) r_fin = ~p_next[WIDTH-1:0] + 1'b1;
`endif
  end

  // Operand values captured at accept. A zero divisor keeps A verbatim so the
  // ZERO path can return it as the remainder unchanged.
  always_comb begin
    a_load = A;
    b_load = B;
`ifdef SEQ_DIV_SIGNED_EN
    if (B != '0) a_load = mag(A);
    b_load = mag(B);
`endif
  end

  // After a successful subtract the top bit of P is always zero.
  assign unused_p_msb = p_q[WIDTH];

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      d_q         <= '0;
      b_q         <= '0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      state_r <= next_state;
      if (accept) begin
        cnt_q       <= '0;
        p_q         <= '0;
        d_q         <= a_load;
        b_q         <= b_load;
        div_by_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
        neg_q_q     <= A[WIDTH-1] ^ B[WIDTH-1];
        neg_r_q     <= A[WIDTH-1];
`endif
      end else if (state_r == S_RUN) begin
        cnt_q <= cnt_q + 1'b1;
        p_q   <= p_next;
        d_q   <= d_next;
        if (cnt_q == LAST) begin
          Q <= q_fin;
          R <= r_fin;
        end
      end else if (state_r == S_ZERO) begin
        Q           <= '1;
        R           <= d_q;
        div_by_zero <= 1'b1;
      end
    end
  end

endmodule
